// File: rtl/snl_pkg.sv
// Shared types and constants for the snakes-and-ladders turn scheduler.
package snl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROLL  = 3'd1,
        S_MOVE  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } snl_state_t;

    localparam int               DIE_W     = 3;
    localparam logic [DIE_W-1:0] DIE_MIN   = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX   = 3'd6;
    localparam logic [1:0]       MAX_BONUS = 2'd2;

endpackage

// File: rtl/snl_pos_regfile.sv
// Per-player square registers: one write port, async read, synchronous clear-all.
module snl_pos_regfile #(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_W       = 6,
    parameter int PID_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [PID_W-1:0] wr_pid,
    input  logic [POS_W-1:0] wr_pos,
    input  logic [PID_W-1:0] rd_pid,
    output logic [POS_W-1:0] rd_pos
);

    logic [POS_W-1:0] pos_q [NUM_PLAYERS];
    logic [POS_W-1:0] pos_d [NUM_PLAYERS];

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            pos_d[i] = pos_q[i];
            if (clr) begin
                pos_d[i] = '0;
            end else if (we && wr_pid == PID_W'(i)) begin
                pos_d[i] = wr_pos;
            end
        end
    end

    always_comb begin
        rd_pos = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (rd_pid == PID_W'(i)) rd_pos = pos_q[i];
        end
    end

    // NOTE: every player must read as square 0 straight out of reset, so this small array is reset entry by entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/snl_turn_scheduler.sv
// Round-robin turn scheduler sharing one dice roller and one move datapath.
// Define SNL_BONUS_ROLL_EN to grant bonus turns on a non-winning legal 6.
module snl_turn_scheduler
    import snl_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int BOARD_SIZE  = 50,
    parameter int POS_W       = 6,
    parameter int PID_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_game,
    output logic             dice_req,
    input  logic             dice_ack,
    input  logic [DIE_W-1:0] dice_val,
    output logic             move_req,
    output logic [PID_W-1:0] move_pid,
    output logic [DIE_W-1:0] move_steps,
    input  logic             move_ack,
    input  logic [POS_W-1:0] move_pos,
    output logic [PID_W-1:0] cur_player,
    output logic             winner_valid,
    output logic [PID_W-1:0] winner_id,
    output logic [15:0]      turn_count
);

    localparam logic [POS_W:0]   LAST_SUM = (POS_W+1)'(BOARD_SIZE - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(BOARD_SIZE - 1);

    snl_state_t       state_q, state_d;
    logic             dice_req_q, dice_req_d;
    logic             move_req_q, move_req_d;
    logic [DIE_W-1:0] steps_q, steps_d;
    logic [PID_W-1:0] cur_player_q, cur_player_d;
    logic             winner_valid_q, winner_valid_d;
    logic [PID_W-1:0] winner_id_q, winner_id_d;
    logic [15:0]      turn_count_q, turn_count_d;
`ifdef SNL_BONUS_ROLL_EN
    logic [1:0]       bonus_q, bonus_d;
    logic             moved_q, moved_d;
`endif

    logic             dice_fire, move_fire;
    logic             pos_we, pos_clr;
    logic [POS_W-1:0] cur_pos;
    logic [POS_W:0]   pos_sum;
    logic [PID_W-1:0] next_player;

    snl_pos_regfile #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .POS_W      (POS_W),
        .PID_W      (PID_W)
    ) u_pos_regfile (
        .clk   (clk),
        .reset (reset),
        .clr   (pos_clr),
        .we    (pos_we),
        .wr_pid(cur_player_q),
        .wr_pos(move_pos),
        .rd_pid(cur_player_q),
        .rd_pos(cur_pos)
    );

    // Acks only count while the matching request is actually raised.
    assign dice_fire   = dice_req_q && dice_ack;
    assign move_fire   = move_req_q && move_ack;
    assign pos_sum     = {1'b0, cur_pos} + (POS_W+1)'(dice_val);
    assign next_player = (cur_player_q == PID_W'(NUM_PLAYERS - 1)) ? '0 : cur_player_q + PID_W'(1);

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        steps_d        = steps_q;
        cur_player_d   = cur_player_q;
        winner_valid_d = winner_valid_q;
        winner_id_d    = winner_id_q;
        turn_count_d   = turn_count_q;
        pos_we         = 1'b0;
        pos_clr        = 1'b0;
`ifdef SNL_BONUS_ROLL_EN
        bonus_d        = bonus_q;
        moved_d        = moved_q;
`endif
        case (state_q)
            S_IDLE: if (start_game) state_d = S_ROLL;
            S_ROLL: begin
                if (dice_fire && dice_val >= DIE_MIN && dice_val <= DIE_MAX) begin
                    if (pos_sum > LAST_SUM) begin
                        state_d = S_CHECK;
`ifdef SNL_BONUS_ROLL_EN
                        moved_d = 1'b0;
`endif
                    end else begin
                        steps_d = dice_val;
                        state_d = S_MOVE;
`ifdef SNL_BONUS_ROLL_EN
                        moved_d = 1'b1;
`endif
                    end
                end
            end
            S_MOVE: begin
                if (move_fire) begin
                    pos_we  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (turn_count_q != 16'hFFFF) turn_count_d = turn_count_q + 16'd1;
                if (cur_pos == LAST_POS) begin
                    winner_valid_d = 1'b1;
                    winner_id_d    = cur_player_q;
                    state_d        = S_DONE;
                end else begin
`ifdef SNL_BONUS_ROLL_EN
                    if (moved_q && steps_q == DIE_MAX && bonus_q < MAX_BONUS) begin
                        bonus_d = bonus_q + 2'd1;
                    end else begin
                        bonus_d      = '0;
                        cur_player_d = next_player;
                    end
`else
                    cur_player_d = next_player;
`endif
                    state_d = start_game ? S_ROLL : S_IDLE;
                end
            end
            S_DONE: begin
                if (!start_game) begin
                    state_d        = S_IDLE;
                    pos_clr        = 1'b1;
                    cur_player_d   = '0;
                    turn_count_d   = '0;
                    winner_valid_d = 1'b0;
                    winner_id_d    = '0;
`ifdef SNL_BONUS_ROLL_EN
                    bonus_d        = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Requests follow the next state, but drop for one cycle after each transfer.
        dice_req_d = (state_d == S_ROLL) && !dice_fire;
        move_req_d = (state_d == S_MOVE) && !move_fire;
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            dice_req_q     <= 1'b0;
            move_req_q     <= 1'b0;
            steps_q        <= '0;
            cur_player_q   <= '0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
            turn_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            dice_req_q     <= dice_req_d;
            move_req_q     <= move_req_d;
            steps_q        <= steps_d;
            cur_player_q   <= cur_player_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
            turn_count_q   <= turn_count_d;
        end
    end

`ifdef SNL_BONUS_ROLL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bonus_q <= '0;
            moved_q <= 1'b0;
        end else begin
            bonus_q <= bonus_d;
            moved_q <= moved_d;
        end
    end
`endif

    assign dice_req     = dice_req_q;
    assign move_req     = move_req_q;
    assign move_pid     = cur_player_q;
    assign move_steps   = steps_q;
    assign cur_player   = cur_player_q;
    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign turn_count   = turn_count_q;

endmodule

// File: doc/snl_turn_scheduler.md
# snl_turn_scheduler

Turn scheduler for the snakes-and-ladders game. It shares one dice roller and one move/board datapath between NUM_PLAYERS players in strict round-robin order and tracks each player's square. It detects the winner and sequences start, pause and restart from the start_game level. It sits between top-level game control and the dice/board datapath that produces the one-hot player position buses.

## Interface
- NUM_PLAYERS, 2: players sharing the datapath, 2..4
- BOARD_SIZE, 50: squares, indexed 0..BOARD_SIZE-1; the last square wins
- POS_W, 6: binary position width, ≥ clog2(BOARD_SIZE)
- PID_W, 2: player id width, ≥ clog2(NUM_PLAYERS)

Ports:
- clk  in  1  game clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_game  in  1  level; high = run, low = pause at the next turn boundary
- dice_req  out  1  roll request, held until dice_ack
- dice_ack  in  1  roll complete; dice_val valid in the same cycle
- dice_val  in  3  rolled value, legal range 1..6
- move_req  out  1  move request, held until move_ack
- move_pid  out  PID_W  player to move; stable while move_req is high
- move_steps  out  3  squares to advance; stable while move_req is high
- move_ack  in  1  move resolved; move_pos valid in the same cycle
- move_pos  in  POS_W  final square after snake/ladder resolution
- cur_player  out  PID_W  player whose turn it is
- winner_valid  out  1  game over
- winner_id  out  PID_W  winning player; valid when winner_valid is high
- turn_count  out  16  completed turns, saturates at 0xFFFF

## Operation
- States: IDLE, ROLL, MOVE, CHECK, DONE. All outputs are registered (Moore).
- IDLE:
  - start_game high → ROLL.
  - On entry from DONE (restart), clear all positions, cur_player, turn_count and winner_valid.
- ROLL:
  - dice_req is high.
  - On dice_ack with dice_val 0 or 7: stay in ROLL and re-request. Not counted as a turn.
  - Legal value with pos+val ≤ BOARD_SIZE-1: latch the value → MOVE.
  - Overshoot (pos+val > BOARD_SIZE-1): turn forfeited, no move issued → CHECK.
- MOVE:
  - move_req is high with move_pid = cur_player and move_steps = latched value.
  - On move_ack, write move_pos into the player's position register → CHECK.
- CHECK (one cycle):
  - Increment turn_count.
  - move_pos == BOARD_SIZE-1: set winner_valid and winner_id → DONE.
  - Otherwise advance cur_player (NUM_PLAYERS-1 wraps to 0). Then start_game high → ROLL, low → IDLE.
- DONE:
  - Holds until start_game is seen low for at least 1 cycle, then → IDLE; the next start_game high restarts.
  - dice_ack and move_ack are ignored.
- Pause: start_game dropping mid-turn does not abort the turn; the turn completes, then → IDLE. Positions are kept; the game resumes with the same cur_player.
- Stray ack while the matching req is low: ignored.

## Timing
- Reset values: all outputs 0, state IDLE, all positions 0.
- Reset asserted mid-operation: immediate asynchronous clear. Any outstanding req drops in the same cycle.
- Handshake:
  - req rises on the clock edge after state entry.
  - A transfer occurs on a clock edge where req and ack are both high.
  - req is low on the following cycle.
  - req does not reassert in the same cycle as its ack.
- Minimum turn is 3 cycles (ROLL, MOVE, CHECK) with same-cycle acks; the next dice_req is high 3 cycles after the previous one.
- Acks may be delayed indefinitely; there is no timeout.
- Arithmetic: overshoot check uses POS_W+1-bit addition; dice_val is zero-extended.
- turn_count saturates at 0xFFFF; it does not wrap.

## Configuration
- SNL_BONUS_ROLL_EN defined:
  - A legal roll of 6 that does not win gives the same player another turn; cur_player is not advanced.
  - At most 2 consecutive bonus turns. A third consecutive 6 moves normally, then the turn passes.
  - The bonus counter clears on any turn pass.
  - Each bonus turn counts in turn_count.
- Undefined: strict alternation regardless of the value rolled.

## Structure
- Package snl_pkg holds:
  - state enum snl_state_t
  - DIE_W = 3, DIE_MIN = 1, DIE_MAX = 6
  - MAX_BONUS = 2
- Sub-module snl_pos_regfile: NUM_PLAYERS×POS_W position registers with one write port, an async read by cur_player, and a synchronous clear-all.

## Test plan
- Reset then start_game high, dice always 3, move_pos = old+3 → p0 and p1 alternate; after 16 turns both at 24; turn_count = 16.
- p0 at 47, dice 5 → no move_req; p0 stays at 47; cur_player → 1; turn_count +1.
- p1 at 45, dice 4, move_pos 49 → winner_valid = 1, winner_id = 1, DONE; later dice_ack ignored.
- dice_val 7 then 2 → exactly one move_req with move_steps 2; turn_count +1 only.
- start_game low while in MOVE with move_ack delayed 5 cycles → turn completes, → IDLE, positions kept; start_game high resumes with the next player.
- With SNL_BONUS_ROLL_EN, p0 rolls 6, 6, 6, 6 → p0 moves 3 times, then cur_player = 1. Without the macro, the players alternate.
